// File: rtl/operand_fetch_unit.sv
// ============================================================================
//  Module   : operand_fetch_unit
//  Brief    : Decodes an MSP430 instruction word, fetches extension words and
//             memory operands, applies autoincrement and hands an
//             {iw, src, dst} bundle to the function unit via valid/ready.
//  Options  : CONSTGEN_EN - enables the R2/R3 source constant generator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch_unit #(
  parameter int         DW     = 16,
  parameter logic [3:0] PC_REG = 4'd0,
  parameter logic [3:0] SP_REG = 4'd1,
  parameter logic [3:0] SR_REG = 4'd2,
  parameter logic [3:0] CG_REG = 4'd3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iw_valid,
  input  logic [DW-1:0] iw,
  input  logic [DW-1:0] pc_in,
  output logic          iw_ready,
  input  logic          flush,
  output logic [3:0]    reg_raddr_a,
  input  logic [DW-1:0] reg_rdata_a,
  output logic [3:0]    reg_raddr_b,
  input  logic [DW-1:0] reg_rdata_b,
  output logic          mem_req,
  output logic [DW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          inc_we,
  output logic [3:0]    inc_reg,
  output logic [DW-1:0] inc_val,
  output logic [DW-1:0] pc_out,
  output logic          fu_valid,
  input  logic          fu_ready,
  output logic [DW-1:0] fu_iw,
  output logic [DW-1:0] fu_src,
  output logic [DW-1:0] fu_dst,
  output logic [DW-1:0] dst_addr,
  output logic          dst_is_mem
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SRC_EXT = 3'd1;
  localparam logic [2:0] S_SRC_RD  = 3'd2;
  localparam logic [2:0] S_DST_EXT = 3'd3;
  localparam logic [2:0] S_DST_RD  = 3'd4;
  localparam logic [2:0] S_ISSUE   = 3'd5;

`ifdef CONSTGEN_EN
  localparam bit c_cg_en = 1'b1;
`else
  localparam bit c_cg_en = 1'b0;
`endif

  logic [2:0]    r_state, w_next;
  logic [DW-1:0] r_iw, r_pc, r_addr, r_src, r_dst, r_dst_addr;
  logic          r_dst_is_mem;

  // In IDLE decode looks straight at the incoming word so a register-only
  // instruction can be issued on the cycle after accept.
  logic [DW-1:0] w_iw;
  logic          w_accept, w_in_ext, w_in_rd, w_ack;
  logic          w_fmt1, w_fmt2, w_jump, w_mode, w_bw, w_ad;
  logic [3:0]    w_mreg, w_dreg;
  logic [1:0]    w_as;
  logic          w_cg, w_abs, w_imm, w_need_sext, w_need_srd;
  logic [DW-1:0] w_cg_val, w_base_a, w_step, w_inc_val, w_lane, w_rd_val;

  assign w_iw     = (r_state == S_IDLE) ? iw : r_iw;
  assign w_accept = iw_valid & (r_state == S_IDLE);
  assign w_in_ext = (r_state == S_SRC_EXT) | (r_state == S_DST_EXT);
  assign w_in_rd  = (r_state == S_SRC_RD)  | (r_state == S_DST_RD);
  assign w_ack    = (w_in_ext | w_in_rd) & mem_ack;

  assign w_fmt1 = (w_iw[15:12] >= 4'd4);
  assign w_fmt2 = (w_iw[15:10] == 6'b000100);
  assign w_jump = (w_iw[15:13] == 3'b001);
  assign w_mode = w_fmt1 | w_fmt2;
  // Format II routes its single operand through the source-mode machinery.
  assign w_mreg = w_fmt1 ? w_iw[11:8] : w_iw[3:0];
  assign w_dreg = w_iw[3:0];
  assign w_as   = w_iw[5:4];
  assign w_bw   = w_iw[6];
  assign w_ad   = w_fmt1 & w_iw[7];

  // Constant generator: R3 in any mode, R2 with As=1x; R2 As=01 is absolute.
  assign w_cg  = c_cg_en & w_mode & ((w_mreg == CG_REG) | ((w_mreg == SR_REG) & w_as[1]));
  assign w_abs = c_cg_en & (w_mreg == SR_REG) & (w_as == 2'b01);

  // Constant value selected by register and addressing mode
  always_comb begin
    w_cg_val = '0;
    if (w_mreg == CG_REG) begin
      case (w_as)
        2'b01:   w_cg_val = DW'(1);
        2'b10:   w_cg_val = DW'(2);
        2'b11:   w_cg_val = '1;
        default: w_cg_val = '0;
      endcase
    end else begin
      w_cg_val = w_as[0] ? DW'(8) : DW'(4);
    end
  end

  assign w_imm       = w_mode & ~w_cg & (w_mreg == PC_REG) & (w_as == 2'b11);
  assign w_need_sext = w_mode & ~w_cg & ((w_as == 2'b01) | w_imm);
  assign w_need_srd  = w_mode & ~w_cg & (w_as != 2'b00) & ~w_imm;
  assign w_base_a    = w_abs ? '0 : reg_rdata_a;
  assign w_step      = (w_bw & (w_mreg != PC_REG) & (w_mreg != SP_REG)) ? DW'(1) : DW'(2);
  assign w_inc_val   = r_addr + w_step;
  // Byte reads pick the lane addressed by bit0 and zero-extend it.
  assign w_lane      = r_addr[0] ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]};
  assign w_rd_val    = w_bw ? w_lane : mem_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: advance on mem_ack or when a stage has nothing to fetch
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = w_need_sext ? S_SRC_EXT :
                                        w_need_srd  ? S_SRC_RD  :
                                        w_ad        ? S_DST_EXT : S_ISSUE;
      S_SRC_EXT: if (w_ack)    w_next = w_need_srd  ? S_SRC_RD  :
                                        w_ad        ? S_DST_EXT : S_ISSUE;
      S_SRC_RD:  if (w_ack)    w_next = w_ad ? S_DST_EXT : S_ISSUE;
      S_DST_EXT: if (w_ack)    w_next = S_DST_RD;
      S_DST_RD:  if (w_ack)    w_next = S_ISSUE;
      S_ISSUE:   if (fu_ready) w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Outputs decoded from state and the latched bundle
  always_comb begin
    iw_ready    = (r_state == S_IDLE);
    fu_valid    = (r_state == S_ISSUE);
    mem_req     = w_in_ext | w_in_rd;
    mem_addr    = '0;
    if (w_in_ext)     mem_addr = {r_pc[DW-1:1], 1'b0};
    else if (w_in_rd) mem_addr = {r_addr[DW-1:1], 1'b0};
    reg_raddr_a = '0;
    reg_raddr_b = '0;
    if ((r_state != S_IDLE) || iw_valid) begin
      reg_raddr_a = w_mreg;
      reg_raddr_b = w_dreg;
    end
    inc_we      = (r_state == S_SRC_RD) & w_ack & (w_as == 2'b11);
    inc_reg     = inc_we ? w_mreg : 4'd0;
    inc_val     = inc_we ? w_inc_val : '0;
    pc_out      = r_pc;
    fu_iw       = r_iw;
    fu_src      = r_src;
    fu_dst      = r_dst;
    dst_addr    = r_dst_addr;
    dst_is_mem  = r_dst_is_mem;
  end

  // Operand datapath: capture on accept, refine on each acknowledged access
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_iw         <= '0;
      r_pc         <= '0;
      r_addr       <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_dst_addr   <= '0;
      r_dst_is_mem <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_iw         <= iw;
          r_pc         <= pc_in;
          r_addr       <= w_base_a;
          r_dst_addr   <= '0;
          r_src        <= w_fmt1 ? (w_cg ? w_cg_val : reg_rdata_a) : '0;
          if (w_jump)      r_dst <= pc_in;
          else if (w_fmt1) r_dst <= reg_rdata_b;
          else if (w_fmt2) r_dst <= w_cg ? w_cg_val : reg_rdata_a;
          else             r_dst <= '0;
          r_dst_is_mem <= w_ad | (w_fmt2 & (w_as != 2'b00) & ~w_cg);
        end
        S_SRC_EXT: if (w_ack) begin
          r_pc <= r_pc + DW'(2);
          if (w_imm) begin
            if (w_fmt1) r_src <= mem_rdata;
            else begin
              r_dst      <= mem_rdata;
              r_dst_addr <= r_pc;
            end
          end else begin
            r_addr <= w_base_a + mem_rdata;
          end
        end
        S_SRC_RD: if (w_ack) begin
          if (w_fmt1) r_src <= w_rd_val;
          else begin
            r_dst      <= w_rd_val;
            r_dst_addr <= r_addr;
          end
          // A register dst equal to the autoincremented register sees the new value.
          if ((w_as == 2'b11) && w_fmt1 && !w_ad && (w_dreg == w_mreg))
            r_dst <= w_inc_val;
        end
        S_DST_EXT: if (w_ack) begin
          r_pc       <= r_pc + DW'(2);
          r_addr     <= reg_rdata_b + mem_rdata;
          r_dst_addr <= reg_rdata_b + mem_rdata;
        end
        S_DST_RD: if (w_ack) r_dst <= w_rd_val;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_unit.sv
// ============================================================================
//  Module   : tb_operand_fetch_unit
//  Brief    : Directed self-checking bench for operand_fetch_unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, iw_valid, flush, mem_ack, fu_ready;
  logic [15:0] iw, pc_in, mem_rdata;
  logic        iw_ready, mem_req, inc_we, fu_valid, dst_is_mem;
  logic [3:0]  reg_raddr_a, reg_raddr_b, inc_reg;
  logic [15:0] reg_rdata_a, reg_rdata_b, mem_addr, inc_val, pc_out;
  logic [15:0] fu_iw, fu_src, fu_dst, dst_addr;

  logic [15:0] regs [0:15];
  logic        tb_we;
  logic [3:0]  tb_wa;
  logic [15:0] tb_wd;

  int errors = 0;
  int checks = 0;

  logic        o_we;
  logic [3:0]  o_reg;
  logic [15:0] o_val;

  operand_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .iw_valid(iw_valid), .iw(iw), .pc_in(pc_in),
    .iw_ready(iw_ready), .flush(flush),
    .reg_raddr_a(reg_raddr_a), .reg_rdata_a(reg_rdata_a),
    .reg_raddr_b(reg_raddr_b), .reg_rdata_b(reg_rdata_b),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .inc_we(inc_we), .inc_reg(inc_reg), .inc_val(inc_val), .pc_out(pc_out),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_iw(fu_iw), .fu_src(fu_src),
    .fu_dst(fu_dst), .dst_addr(dst_addr), .dst_is_mem(dst_is_mem)
  );

  always #5 clk = ~clk;

  assign reg_rdata_a = regs[reg_raddr_a];
  assign reg_rdata_b = regs[reg_raddr_b];

  // Register file model: bench loads and autoincrement writes land on the edge
  always @(posedge clk) begin
    if (tb_we)  regs[tb_wa]   <= tb_wd;
    if (inc_we) regs[inc_reg] <= inc_val;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic issue(input logic [15:0] w, input logic [15:0] p);
    check("iw_ready_pre", {15'd0, iw_ready}, 16'd1);
    iw = w; pc_in = p; iw_valid = 1'b1;
    @(negedge clk);
    iw_valid = 1'b0;
  endtask

  task automatic serve(input string tag, input logic [15:0] addr, input logic [15:0] data,
                       input int delay, output logic iwe, output logic [3:0] ireg,
                       output logic [15:0] ival);
    int n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    check({tag, "_req"}, {15'd0, mem_req}, 16'd1);
    check({tag, "_addr"}, mem_addr, addr);
    repeat (delay) @(negedge clk);
    if (delay > 0) check({tag, "_hold"}, mem_addr, addr);
    mem_rdata = data; mem_ack = 1'b1;
    #1;
    iwe = inc_we; ireg = inc_reg; ival = inc_val;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'h0000;
  endtask

  task automatic wait_fu(input string tag);
    int n = 0;
    while (!fu_valid && n < 30) begin @(negedge clk); n++; end
    check({tag, "_fu_valid"}, {15'd0, fu_valid}, 16'd1);
  endtask

  task automatic retire(input string tag);
    fu_ready = 1'b1;
    @(negedge clk);
    fu_ready = 1'b0;
    check({tag, "_idle"}, {14'd0, iw_ready, fu_valid}, 16'h0002);
  endtask

  initial begin
    rst_n = 1'b0; iw_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0; fu_ready = 1'b0;
    iw = 16'h0000; pc_in = 16'h0000; mem_rdata = 16'h0000;
    tb_we = 1'b0; tb_wa = 4'd0; tb_wd = 16'h0000;
    for (int i = 0; i < 16; i++) set_reg(4'(i), 16'h0000);

    // Reset state
    check("rst_ready", {15'd0, iw_ready}, 16'd1);
    check("rst_fu_valid", {15'd0, fu_valid}, 16'd0);
    check("rst_mem_req", {15'd0, mem_req}, 16'd0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_inc_we", {15'd0, inc_we}, 16'd0);
    check("rst_pc_out", pc_out, 16'h0000);
    check("rst_dst_is_mem", {15'd0, dst_is_mem}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD R4,R5 : register only, one-cycle latency
    set_reg(4'd4, 16'h0003);
    set_reg(4'd5, 16'h0004);
    issue(16'h5405, 16'h1000);
    check("add_rr_valid", {15'd0, fu_valid}, 16'd1);
    check("add_rr_src", fu_src, 16'h0003);
    check("add_rr_dst", fu_dst, 16'h0004);
    check("add_rr_iw", fu_iw, 16'h5405);
    check("add_rr_mem_req", {15'd0, mem_req}, 16'd0);
    check("add_rr_dim", {15'd0, dst_is_mem}, 16'd0);
    check("add_rr_pc", pc_out, 16'h1000);
    retire("add_rr");

    // MOV #0x1234,R5 : immediate
    issue(16'h4035, 16'h8002);
    serve("imm_ext", 16'h8002, 16'h1234, 0, o_we, o_reg, o_val);
    check("imm_inc_we", {15'd0, o_we}, 16'd0);
    wait_fu("imm");
    check("imm_src", fu_src, 16'h1234);
    check("imm_dst", fu_dst, 16'h0004);
    check("imm_pc", pc_out, 16'h8004);
    retire("imm");

    // ADD 2(R4),4(R5) : four accesses, each acked after 3 cycles
    set_reg(4'd4, 16'h0200);
    set_reg(4'd5, 16'h0200);
    issue(16'h5495, 16'h3000);
    serve("idx_sext", 16'h3000, 16'h0002, 3, o_we, o_reg, o_val);
    serve("idx_srd",  16'h0202, 16'hBEEF, 3, o_we, o_reg, o_val);
    serve("idx_dext", 16'h3002, 16'h0004, 3, o_we, o_reg, o_val);
    serve("idx_drd",  16'h0204, 16'h5A5A, 3, o_we, o_reg, o_val);
    wait_fu("idx");
    check("idx_src", fu_src, 16'hBEEF);
    check("idx_dst", fu_dst, 16'h5A5A);
    check("idx_daddr", dst_addr, 16'h0204);
    check("idx_dim", {15'd0, dst_is_mem}, 16'd1);
    check("idx_pc", pc_out, 16'h3004);
    repeat (2) @(negedge clk);
    check("idx_hold_valid", {15'd0, fu_valid}, 16'd1);
    check("idx_hold_src", fu_src, 16'hBEEF);
    retire("idx");

    // MOV.B @R6+,R7 : odd byte address, +1 autoincrement
    set_reg(4'd6, 16'h0301);
    set_reg(4'd7, 16'h0055);
    issue(16'h4677, 16'h4000);
    serve("ainc", 16'h0300, 16'hAB12, 0, o_we, o_reg, o_val);
    check("ainc_we", {15'd0, o_we}, 16'd1);
    check("ainc_reg", {12'd0, o_reg}, 16'd6);
    check("ainc_val", o_val, 16'h0302);
    check("ainc_we_pulse", {15'd0, inc_we}, 16'd0);
    wait_fu("ainc");
    check("ainc_src", fu_src, 16'h00AB);
    check("ainc_dst", fu_dst, 16'h0055);
    retire("ainc");

    // MOV @R8+,R8 : word +2, dst register sees the incremented value
    set_reg(4'd8, 16'h0500);
    issue(16'h4838, 16'h4100);
    serve("ainc8", 16'h0500, 16'h7777, 1, o_we, o_reg, o_val);
    check("ainc8_val", o_val, 16'h0502);
    wait_fu("ainc8");
    check("ainc8_src", fu_src, 16'h7777);
    check("ainc8_dst", fu_dst, 16'h0502);
    retire("ainc8");

    // JMP : pc_in on fu_dst, no fetches
    issue(16'h3C05, 16'h7000);
    check("jmp_valid", {15'd0, fu_valid}, 16'd1);
    check("jmp_src", fu_src, 16'h0000);
    check("jmp_dst", fu_dst, 16'h7000);
    check("jmp_mem_req", {15'd0, mem_req}, 16'd0);
    retire("jmp");

    // RRC.B 4(R9) : format II, address and PC both wrap
    set_reg(4'd9, 16'hFFFF);
    issue(16'h1059, 16'hFFFE);
    serve("f2_ext", 16'hFFFE, 16'h0004, 0, o_we, o_reg, o_val);
    serve("f2_rd",  16'h0002, 16'hCD34, 2, o_we, o_reg, o_val);
    wait_fu("f2");
    check("f2_src", fu_src, 16'h0000);
    check("f2_dst", fu_dst, 16'h00CD);
    check("f2_daddr", dst_addr, 16'h0003);
    check("f2_dim", {15'd0, dst_is_mem}, 16'd1);
    check("f2_pc", pc_out, 16'h0000);
    retire("f2");

    // Reset while SRC_RD waits; a late ack must be ignored
    set_reg(4'd4, 16'h0200);
    issue(16'h4435, 16'h5000);
    check("rstf_req", {15'd0, mem_req}, 16'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstf_mem_req", {15'd0, mem_req}, 16'd0);
    check("rstf_ready", {15'd0, iw_ready}, 16'd1);
    check("rstf_fu_valid", {15'd0, fu_valid}, 16'd0);
    check("rstf_pc", pc_out, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    #1;
    check("rstf_late_inc", {15'd0, inc_we}, 16'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    check("rstf_late_state", {13'd0, iw_ready, fu_valid, mem_req}, 16'h0004);

    // Flush while SRC_RD waits
    issue(16'h4435, 16'h5000);
    check("flf_req", {15'd0, mem_req}, 16'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flf_mem_req", {15'd0, mem_req}, 16'd0);
    check("flf_ready", {15'd0, iw_ready}, 16'd1);
    check("flf_fu_valid", {15'd0, fu_valid}, 16'd0);
    mem_ack = 1'b1;
    #1;
    check("flf_late_inc", {15'd0, inc_we}, 16'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    check("flf_late_state", {13'd0, iw_ready, fu_valid, mem_req}, 16'h0004);

    // MOV #1,R5 encoded via R3 As=01
    set_reg(4'd3, 16'h0100);
    issue(16'h4315, 16'h6000);
`ifdef CONSTGEN_EN
    check("cg_valid", {15'd0, fu_valid}, 16'd1);
    check("cg_mem_req", {15'd0, mem_req}, 16'd0);
    check("cg_src", fu_src, 16'h0001);
    check("cg_pc", pc_out, 16'h6000);
`else
    serve("cg_ext", 16'h6000, 16'h0010, 0, o_we, o_reg, o_val);
    serve("cg_rd",  16'h0110, 16'h4242, 0, o_we, o_reg, o_val);
    wait_fu("cg");
    check("cg_src", fu_src, 16'h4242);
    check("cg_pc", pc_out, 16'h6002);
`endif
    retire("cg");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
Upstream sequencer for the 16/8-bit MSP430 function unit. It accepts a fetched instruction word, decodes the format and addressing modes, and fetches extension words and memory operands. It applies autoincrement side effects, then presents a stable {IW, src, dst} bundle to the function unit with a valid/ready handshake. It also reports where the dst operand lives for the writeback stage.

Parameters:
DW, 16, data/address width (fixed at 16; no extended/address instructions)
PC_REG, 0, register index of PC
SP_REG, 1, register index of SP
SR_REG, 2, register index of SR / constant generator 1
CG_REG, 3, register index of constant generator 2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
iw_valid  in  1  instruction word available
iw  in  16  instruction word
pc_in  in  16  PC after the instruction word fetch, sampled with iw
iw_ready  out  1  unit can accept iw (IDLE only)
flush  in  1  synchronous abort to IDLE (branch/interrupt)
reg_raddr_a  out  4  register file read port A address (src side)
reg_rdata_a  in  16  port A data, combinational
reg_raddr_b  out  4  register file read port B address (dst side)
reg_rdata_b  in  16  port B data, combinational
mem_req  out  1  memory word read request
mem_addr  out  16  word read address (bit0 forced 0)
mem_rdata  in  16  read data, valid with mem_ack
mem_ack  in  1  read complete
inc_we  out  1  one-cycle autoincrement write strobe
inc_reg  out  4  register to increment
inc_val  out  16  new register value
pc_out  out  16  PC advanced past the consumed extension words
fu_valid  out  1  operand bundle valid
fu_ready  in  1  function unit accepts bundle
fu_iw, fu_src, fu_dst  out  16 each  bundle to the function unit
dst_addr  out  16  effective dst address (memory dst only)
dst_is_mem  out  1  dst is memory (Ad=1 or single-op As!=00)

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; every output 0 except iw_ready=1; any in-flight mem_req is dropped at that edge and a late mem_ack is ignored. Reset has priority over flush; flush behaves identically but preserves nothing.
- Decode: IW[15:12]>=4 = format I (src reg IW[11:8], Ad IW[7], BW IW[6], As IW[5:4], dst reg IW[3:0]). IW[15:10]=000100 = format II: its operand uses As/reg IW[3:0] and is delivered on fu_dst, with fu_src=0. IW[15:13]=001 = jump: fu_dst=pc_in, fu_src=0, no fetches.
- FSM: IDLE -> SRC_EXT -> SRC_RD -> DST_EXT -> DST_RD -> ISSUE. Unneeded states are skipped. Transitions occur on the mem_ack cycle or when the state needs no access.
- Accept: iw_valid & iw_ready latches iw and pc_in. A register-only instruction asserts fu_valid on the next cycle (latency 1).
- src modes: As=00 Rn. As=01 fetch ext word at PC, PC+=2, then read M[Rn+X]. As=10 read M[Rn]. As=11 read M[Rn] then autoincrement. Rn=PC with As=11 is immediate: the ext word is the operand, PC+=2.
- Autoincrement: +1 for byte ops, +2 for word ops; always +2 for PC and SP. inc_we pulses in the mem_ack cycle. Later dst reads see the new value (the register file writes at the edge).
- dst Ad=1: fetch ext word, PC+=2, then dst_addr=Rdst+X and read M[dst_addr]. Format II As=01/10/11 follows the src mode rules for its single operand, with dst_addr set.
- Address arithmetic is modulo 2^16 and wraps silently.
- Byte ops: memory reads are word-wide. Address bit0=1 selects mem_rdata[15:8], else [7:0]; the operand is zero-extended. Register operands are passed unmasked.
- mem_req is held with a constant mem_addr until mem_ack. mem_ack is honoured in any cycle mem_req=1, including the first; mem_ack with mem_req=0 is ignored.
- ISSUE: fu_valid stays high with a stable bundle until fu_valid & fu_ready, then the FSM returns to IDLE. pc_out is valid with fu_valid and holds until the next accept.

Optional Feature:
CONSTGEN_EN defined: src constant generator replaces register/memory access, with no fetch and no autoincrement:
- R3: As 00/01/10/11 give 0/1/2/0xFFFF.
- R2: As=10 gives 4, As=11 gives 8, As=01 is absolute addressing (base 0).
CONSTGEN_EN undefined: R2/R3 are ordinary registers in every mode.

Test Plan:
- ADD R4,R5 (0x5405), R4=3, R5=4 -> fu_valid 1 cycle after accept, fu_src=3, fu_dst=4, no mem_req, dst_is_mem=0.
- MOV #0x1234,R5 (0x4035), pc_in=0x8002, M[0x8002]=0x1234 -> mem_addr=0x8002, fu_src=0x1234, pc_out=0x8004.
- ADD 2(R4),4(R5) (0x5495), R4=R5=0x0200, mem_ack delayed 3 cycles each -> four reads, fu_src=M[0x0202], dst_addr=0x0204, pc_out=pc_in+4.
- MOV.B @R6+,R7 (0x4677), R6=0x0301, M[0x0300]=0xAB12 -> fu_src=0x00AB, inc_we pulse with inc_reg=6, inc_val=0x0302.
- rst_n low (or flush) while SRC_RD is waiting for mem_ack -> next cycle mem_req=0, iw_ready=1, fu_valid=0, and a later mem_ack is ignored.
- CONSTGEN_EN defined, MOV #1,R5 (0x4315) -> fu_src=1 with no mem_req; CONSTGEN_EN undefined -> mem_req to M[R3+X].
